// File: rtl/multiport_regfile_pkg.sv
// Shared sizing defaults and the hard-wired zero register index for the multiport register file.
package multiport_regfile_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
    localparam int unsigned X0_IDX    = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writer scoreboard: one busy bit per register, issue sets, write-back clears, set beats clear.
module regfile_scoreboard
    import multiport_regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       iss_valid,
    input  logic [$clog2(NREGS)-1:0]   iss_rd,
    input  logic [NREGS-1:0]           clr_mask,
    output logic [NREGS-1:0]           busy_vec
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear first so a same-edge issue to the same register keeps it pending.
    always_comb begin
        busy_d = busy_q & ~clr_mask;
        if (iss_valid && (iss_rd != AW'(X0_IDX))) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/multiport_regfile.sv
// Multi-read/multi-write register file with x0 hard-wired to zero, optional write forwarding and a busy scoreboard.
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]             rd_data,
    output logic [NRD-1:0]                  rd_busy,
    input  logic [NWR-1:0]                  wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]             wr_data,
    input  logic                            iss_valid,
    input  logic [$clog2(NREGS)-1:0]        iss_rd,
    output logic [NREGS-1:0]                busy_vec
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] clr_mask;
    logic [AW-1:0]    ra;
    logic [XLEN-1:0]  rdat;
    logic             hit;
    logic             ihit;

    // Ports are visited in ascending order so the highest-numbered write lands last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NWR); p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(X0_IDX))) begin
                    regs_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int p = 0; p < int'(NWR); p++) begin
            if (wr_en[p]) begin
                clr_mask[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_mask  (clr_mask),
        .busy_vec  (busy_vec)
    );

    // Forwarding is suppressed in reset so reads show the stored (cleared) contents.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdat    = '0;
        hit     = 1'b0;
        ihit    = 1'b0;
        for (int k = 0; k < int'(NRD); k++) begin
            ra   = rd_addr[k*AW +: AW];
            rdat = regs_q[ra];
            hit  = 1'b0;
            ihit = iss_valid && (iss_rd == ra);
            if ((BYPASS != 0) && rst_n && (ra != AW'(X0_IDX))) begin
                for (int p = 0; p < int'(NWR); p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) begin
                        rdat = wr_data[p*XLEN +: XLEN];
                        hit  = 1'b1;
                    end
                end
            end
            rd_data[k*XLEN +: XLEN] = rdat;
            rd_busy[k]              = busy_vec[ra] & ~(hit & ~ihit);
        end
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have ports: clk  in  1  clock; one clock, all state on rising edge.
REQ-007 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: rd_addr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-009 SHALL have ports: rd_data  out  NRD*XLEN  packed read data.
REQ-010 SHALL have ports: rd_busy  out  NRD  scoreboard busy flag of each read address.
REQ-011 SHALL have ports: wr_en  in  NWR  per-port write enable.
REQ-012 SHALL have ports: wr_addr  in  NWR*AW  packed write addresses.
REQ-013 SHALL have ports: wr_data  in  NWR*XLEN  packed write data.
REQ-014 SHALL have ports: iss_valid  in  1  issue: mark iss_rd busy.
REQ-015 SHALL have ports: iss_rd  in  AW  destination register being issued.
REQ-016 SHALL have ports: busy_vec  out  NREGS  full scoreboard, bit i = register i pending.

Function
REQ-017 Register 0 SHALL read 0 and never be written or marked busy; rd_busy/busy_vec bit 0 always 0.
REQ-018 Reads SHALL be combinational from rd_addr; writes SHALL commit on the clk edge with wr_en high.
REQ-019 With BYPASS=1, a read whose address matches an enabled write (addr != 0) in the same cycle SHALL return that wr_data; BYPASS=0 returns the stored (old) value.
REQ-020 Two enabled write ports to the same nonzero address SHALL resolve with the higher-numbered port winning, both for storage and bypass.
REQ-021 A write on any port SHALL clear the busy bit of its address on the same edge.
REQ-022 iss_valid SHALL set busy[iss_rd] on the clk edge; iss_valid with iss_rd=0 SHALL be ignored.
REQ-023 Simultaneous issue and write to the same register SHALL leave it busy (set wins over clear).
REQ-024 rd_busy[k] SHALL reflect stored busy state, except that with BYPASS=1 a same-cycle write to that address forces rd_busy[k]=0 unless iss_valid targets it.
REQ-025 Issuing to an already-busy register SHALL keep it busy (no counting; single pending writer).
REQ-026 Out-of-range (unused) packed port bits SHALL not exist; all widths derive from parameters.

Reset
REQ-027 While rst_n is low at a clk edge, all registers SHALL clear to 0 and all busy bits to 0; writes and issues that cycle SHALL be dropped.
REQ-028 During reset, rd_data SHALL show stored values (0 after first reset edge), no bypass; rd_busy and busy_vec SHALL be 0 after the first reset edge.
REQ-029 Reset asserted mid-operation SHALL discard pending busy state without further writes.

Structure
REQ-030 A shared package SHALL hold default XLEN, NREGS, AW and the x0 index constant.
REQ-031 One sub-module SHALL exist: regfile_scoreboard (busy bits, set/clear priority, busy_vec); storage, write arbitration and bypass stay in the top.
REQ-032 No initial blocks or test preloads SHALL be used; the only initialisation is reset.

Verification
REQ-033 Reset then read all ports at addr 5 -> rd_data=0, busy_vec=0.
REQ-034 wr port0 x3=0x1234, same cycle read x3 -> BYPASS=1: 0x1234; BYPASS=0: 0, then 0x1234 next cycle.
REQ-035 Both ports write x7 (port0=0xAA, port1=0xBB) -> x7 reads 0xBB; write x0=0xFF -> x0 reads 0.
REQ-036 iss x9; next cycle busy_vec[9]=1; same cycle write x9=5 and iss x9 -> busy stays 1, x9=5.
REQ-037 iss x4, write x4=0x10 later -> busy clears that edge, rd_busy=0 same cycle with BYPASS=1.
REQ-038 Fill x1..x31 and mark busy, pulse rst_n low one edge -> all regs 0, busy_vec=0, write in that cycle lost.
